// File: rtl/prf_dbg_pkg.sv
// Shared types and constants for the PRF debug sequencer.
package prf_dbg_pkg;

    localparam int PHYS_LOG = 7;
    localparam int DATA_W   = 64;

    // Byte-lane field of the debug address (8 lanes per PRF word).
    localparam int LANE_W = 3;

    // Lane 7 write commits the staged word; lane 0 read always refetches.
    localparam logic [LANE_W-1:0] LANE_COMMIT = 3'd7;
    localparam logic [LANE_W-1:0] LANE_FETCH  = 3'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/prf_debug_sequencer.sv
// Byte-wide debug access sequencer in front of the PRF debug word port.
// Writes are staged a byte at a time and committed on lane 7; reads are
// served from a word snapshot refreshed on lane 0 or on a snapshot miss.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; fields latched on acceptance
// STALL  | core stalled, waiting for pipeQuiet_i or the timeout
// ACCESS | one-cycle PRF word write strobe or read capture
// RESP   | one-cycle response pulse (data, or error on timeout)
module prf_debug_sequencer
    import prf_dbg_pkg::*;
#(
    parameter int INDEX   = PHYS_LOG,
    parameter int WIDTH   = DATA_W,
    parameter int BYTE_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dbgReqValid_i,
    output logic                      dbgReqReady_o,
    input  logic                      dbgReqWrite_i,
    input  logic [INDEX+LANE_W-1:0]   dbgReqAddr_i,
    input  logic [BYTE_W-1:0]         dbgReqWrData_i,
    output logic                      dbgRspValid_o,
    output logic [BYTE_W-1:0]         dbgRspData_o,
    output logic                      dbgRspErr_o,
    output logic                      stallReq_o,
    input  logic                      pipeQuiet_i,
    output logic [INDEX-1:0]          prfAddr_o,
    output logic [WIDTH-1:0]          prfWrData_o,
    output logic                      prfWrEn_o,
    input  logic [WIDTH-1:0]          prfRdData_i
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state;
    logic [INDEX-1:0]    idxQ;
    logic [LANE_W-1:0]   laneQ;
    logic                writeQ;
    logic [WIDTH-1:0]    staging;
    logic [WIDTH-1:0]    snapshot;
    logic [INDEX-1:0]    bufIdx;
    logic                bufValid;
    logic [7:0]          stallCnt;

    logic                stallReq;
    logic                prfWrEn;
    logic                rspValid;
    logic                rspErr;
    logic [BYTE_W-1:0]   rspData;

    logic [INDEX-1:0]    reqIdx;
    logic [LANE_W-1:0]   reqLane;
    logic                reqHit;
    logic                reqNeedsPrf;
    logic [7:0]          stallNext;
    logic                timeoutHit;

    assign reqIdx  = dbgReqAddr_i[INDEX+LANE_W-1:LANE_W];
    assign reqLane = dbgReqAddr_i[LANE_W-1:0];
    assign reqHit  = bufValid && (reqIdx == bufIdx);

    // Only commits, fetches and snapshot misses need to touch the PRF.
    assign reqNeedsPrf = dbgReqWrite_i ? (reqLane == LANE_COMMIT)
                                       : ((reqLane == LANE_FETCH) || !reqHit);

    // Counter saturates so a large TIMEOUT can never be skipped by a wrap.
    assign stallNext  = (stallCnt == 8'hFF) ? 8'hFF : stallCnt + 8'd1;
    assign timeoutHit = (stallNext >= TIMEOUT_CNT);

    // Sequencer FSM with registered outputs, staging and snapshot storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idxQ     <= '0;
            laneQ    <= '0;
            writeQ   <= 1'b0;
            staging  <= '0;
            snapshot <= '0;
            bufIdx   <= '0;
            bufValid <= 1'b0;
            stallCnt <= '0;
            stallReq <= 1'b0;
            prfWrEn  <= 1'b0;
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspData  <= '0;
        end else begin
            prfWrEn  <= 1'b0;
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspData  <= '0;
            case (state)
                IDLE: begin
                    if (dbgReqValid_i) begin
                        idxQ   <= reqIdx;
                        laneQ  <= reqLane;
                        writeQ <= dbgReqWrite_i;
                        if (dbgReqWrite_i) begin
                            staging[int'(reqLane)*BYTE_W +: BYTE_W] <= dbgReqWrData_i;
                        end
                        if (reqNeedsPrf) begin
                            state    <= STALL;
                            stallCnt <= '0;
                            stallReq <= 1'b1;
                        end else begin
                            state    <= RESP;
                            rspValid <= 1'b1;
                            if (!dbgReqWrite_i) begin
                                rspData <= snapshot[int'(reqLane)*BYTE_W +: BYTE_W];
                            end
                        end
                    end
                end
                STALL: begin
                    stallCnt <= stallNext;
                    // A quiet pipe on the last allowed cycle still wins over the timeout.
                    if (pipeQuiet_i) begin
                        state   <= ACCESS;
                        prfWrEn <= writeQ;
                    end else if (timeoutHit) begin
                        state    <= RESP;
                        stallReq <= 1'b0;
                        rspValid <= 1'b1;
                        rspErr   <= 1'b1;
                        bufValid <= 1'b0;
                    end
                end
                ACCESS: begin
                    state    <= RESP;
                    stallReq <= 1'b0;
                    rspValid <= 1'b1;
                    if (writeQ) begin
                        staging <= '0;
                        if (idxQ == bufIdx) begin
                            snapshot <= staging;
                        end
                    end else begin
                        snapshot <= prfRdData_i;
                        bufIdx   <= idxQ;
                        bufValid <= 1'b1;
                        rspData  <= prfRdData_i[int'(laneQ)*BYTE_W +: BYTE_W];
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    stallReq <= 1'b0;
                end
            endcase
        end
    end

    // Ready is gated by reset so it only shows once reset is released.
    assign dbgReqReady_o = (state == IDLE) && reset;
    assign dbgRspValid_o = rspValid;
    assign dbgRspData_o  = rspData;
    assign dbgRspErr_o   = rspErr;
    assign stallReq_o    = stallReq;
    assign prfAddr_o     = idxQ;
    assign prfWrData_o   = staging;
    assign prfWrEn_o     = prfWrEn;

endmodule

// File: tb/tb_prf_debug_sequencer.sv
// Self-checking bench for prf_debug_sequencer: constant vector table,
// a reset-abort sequence, and random requests against a byte-level model.
module tb_prf_debug_sequencer;

    localparam int IDX_W = 7;
    localparam int TO    = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dbgReqValid_i;
    logic        dbgReqReady_o;
    logic        dbgReqWrite_i;
    logic [9:0]  dbgReqAddr_i;
    logic [7:0]  dbgReqWrData_i;
    logic        dbgRspValid_o;
    logic [7:0]  dbgRspData_o;
    logic        dbgRspErr_o;
    logic        stallReq_o;
    logic        pipeQuiet_i;
    logic [6:0]  prfAddr_o;
    logic [63:0] prfWrData_o;
    logic        prfWrEn_o;
    logic [63:0] prfRdData_i;

    always #5 clk = ~clk;

    prf_debug_sequencer #(
        .INDEX(IDX_W), .WIDTH(64), .BYTE_W(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .dbgReqValid_i(dbgReqValid_i), .dbgReqReady_o(dbgReqReady_o),
        .dbgReqWrite_i(dbgReqWrite_i), .dbgReqAddr_i(dbgReqAddr_i),
        .dbgReqWrData_i(dbgReqWrData_i),
        .dbgRspValid_o(dbgRspValid_o), .dbgRspData_o(dbgRspData_o),
        .dbgRspErr_o(dbgRspErr_o), .stallReq_o(stallReq_o),
        .pipeQuiet_i(pipeQuiet_i), .prfAddr_o(prfAddr_o),
        .prfWrData_o(prfWrData_o), .prfWrEn_o(prfWrEn_o),
        .prfRdData_i(prfRdData_i)
    );

    // PRF environment: word memory with a load port used during reset.
    logic        loadEn = 1'b0;
    logic [6:0]  loadAddr = '0;
    logic [63:0] loadData = '0;
    logic [63:0] prfMem [0:127];
    int          envWrites = 0;

    always @(posedge clk) begin
        if (loadEn) prfMem[loadAddr] <= loadData;
        else if (prfWrEn_o) begin
            prfMem[prfAddr_o] <= prfWrData_o;
            envWrites <= envWrites + 1;
        end
    end
    assign prfRdData_i = prfMem[prfAddr_o];

    // Reference model state (byte-level view of the sequencer).
    logic [63:0] refMem [0:127];
    logic [7:0]  mStage [8];
    logic [63:0] mSnap;
    logic [6:0]  mBufIdx;
    bit          mBufValid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          wr;
        logic [6:0]  idx;
        logic [2:0]  lane;
        logic [7:0]  data;
        int          k;
        int          lat;
        bit          err;
        logic [7:0]  rdata;
        bit          wrExp;
        logic [63:0] wword;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] stageWord();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = mStage[i];
        return w;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mStage[i] = 8'h00;
        mSnap = '0;
        mBufIdx = '0;
        mBufValid = 0;
    endtask

    // One request; k = number of leading STALL cycles with pipeQuiet_i low.
    task automatic doReq(input bit wr, input logic [6:0] idx, input logic [2:0] lane,
                         input logic [7:0] data, input int k,
                         output int obsLat, output bit obsErr,
                         output logic [7:0] obsData, output logic [63:0] obsWrWord);
        bit          needs;
        int          expLat;
        bit          expErr;
        logic [7:0]  expData;
        int          expStall;
        bit          expWr;
        logic [63:0] expWord;
        int          w;
        int          stallSeen;
        int          wrSeen;
        int          wrCyc;
        logic [6:0]  wrAddr;
        bit          done;
        obsLat = 0; obsErr = 0; obsData = '0; obsWrWord = '0;
        stallSeen = 0; wrSeen = 0; wrCyc = 0; wrAddr = '0; done = 0;
        expWr = 0; expErr = 0; expData = '0; expStall = 0; expWord = '0;

        needs = wr ? (lane == 3'd7) : ((lane == 3'd0) || !(mBufValid && (mBufIdx == idx)));
        if (wr) mStage[lane] = data;
        if (!needs) begin
            expLat = 1;
            if (!wr) expData = mSnap[int'(lane)*8 +: 8];
        end else if (k >= TO) begin
            expLat = 1 + TO;
            expErr = 1;
            expStall = TO;
            mBufValid = 0;
        end else begin
            expLat = 3 + k;
            expStall = k + 2;
            if (wr) begin
                expWr = 1;
                expWord = stageWord();
                refMem[idx] = expWord;
                if (idx == mBufIdx) mSnap = expWord;
                for (int i = 0; i < 8; i++) mStage[i] = 8'h00;
            end else begin
                mSnap = refMem[idx];
                mBufIdx = idx;
                mBufValid = 1;
                expData = mSnap[int'(lane)*8 +: 8];
            end
        end

        w = 0;
        while (dbgReqReady_o !== 1'b1 && w < 5) begin
            @(negedge clk);
            w++;
        end
        check("ready", dbgReqReady_o, 1);
        dbgReqValid_i  = 1'b1;
        dbgReqWrite_i  = wr;
        dbgReqAddr_i   = {idx, lane};
        dbgReqWrData_i = data;
        @(negedge clk);
        dbgReqValid_i  = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            pipeQuiet_i = (c >= k + 1);
            if (stallReq_o) stallSeen++;
            if (prfWrEn_o) begin
                wrSeen++;
                wrCyc = c;
                wrAddr = prfAddr_o;
                obsWrWord = prfWrData_o;
            end
            if (dbgRspValid_o) begin
                done = 1;
                obsLat = c;
                obsErr = dbgRspErr_o;
                obsData = dbgRspData_o;
            end else begin
                @(negedge clk);
            end
        end
        check("rsp_seen", done, 1);
        check("latency", obsLat, expLat);
        check("rsp_err", obsErr, expErr);
        check("rsp_data", obsData, expData);
        check("stall_cycles", stallSeen, expStall);
        check("write_count", wrSeen, expWr);
        if (expWr) begin
            check("wr_addr", wrAddr, idx);
            check("wr_word", obsWrWord, expWord);
            check("wr_cycle", wrCyc, k + 2);
        end
    endtask

    int          oLat;
    bit          oErr;
    logic [7:0]  oData;
    logic [63:0] oWord;

    initial begin
        int w0;
        logic [63:0] val;
        dbgReqValid_i = 0; dbgReqWrite_i = 0; dbgReqAddr_i = '0; dbgReqWrData_i = '0;
        pipeQuiet_i = 1;
        modelReset();

        // Load the PRF while the sequencer is held in reset.
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (i == 9) val = 64'hDEADBEEFCAFEF00D;
            else if (i == 4) val = 64'h0102030405060708;
            else if (i == 2) val = 64'h1122334455667788;
            else val = {$urandom, $urandom};
            loadEn = 1; loadAddr = 7'(i); loadData = val;
            refMem[i] = val;
        end
        @(negedge clk);
        loadEn = 0;
        check("rst_ready_held", dbgReqReady_o, 0);
        reset = 1;
        #1;
        check("rst_ready", dbgReqReady_o, 1);
        check("rst_stall", stallReq_o, 0);
        check("rst_rspvalid", dbgRspValid_o, 0);
        check("rst_rsperr", dbgRspErr_o, 0);
        check("rst_rspdata", dbgRspData_o, 0);
        check("rst_wren", prfWrEn_o, 0);
        check("rst_addr", prfAddr_o, 0);
        check("rst_wrdata", prfWrData_o, 0);
        @(negedge clk);

        // wr idx lane data k | lat err rdata wrExp wword
        for (int i = 0; i < 7; i++)
            vecs.push_back('{1, 7'd5, 3'(i), 8'(8'h11 * (i + 1)), 0, 1, 0, 8'h00, 0, 64'h0});
        vecs.push_back('{1, 7'd5, 3'd7, 8'h88, 0, 3, 0, 8'h00, 1, 64'h8877665544332211});
        vecs.push_back('{0, 7'd9, 3'd0, 8'h00, 0, 3, 0, 8'h0D, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd1, 8'h00, 0, 1, 0, 8'hF0, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd2, 8'h00, 0, 1, 0, 8'hFE, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd3, 8'h00, 0, 1, 0, 8'hCA, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd4, 8'h00, 0, 1, 0, 8'hEF, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd5, 8'h00, 0, 1, 0, 8'hBE, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd6, 8'h00, 0, 1, 0, 8'hAD, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd7, 8'h00, 0, 1, 0, 8'hDE, 0, 64'h0});
        vecs.push_back('{0, 7'd5, 3'd3, 8'h00, 0, 3, 0, 8'h44, 0, 64'h0});
        vecs.push_back('{1, 7'd6, 3'd0, 8'h5A, 0, 1, 0, 8'h00, 0, 64'h0});
        vecs.push_back('{1, 7'd6, 3'd7, 8'hAB, 5, 6, 1, 8'h00, 0, 64'h0});
        vecs.push_back('{1, 7'd6, 3'd7, 8'hAB, 0, 3, 0, 8'h00, 1, 64'hAB0000000000005A});
        vecs.push_back('{0, 7'd4, 3'd0, 8'h00, 1, 4, 0, 8'h08, 0, 64'h0});
        vecs.push_back('{0, 7'd2, 3'd3, 8'h00, 0, 3, 0, 8'h55, 0, 64'h0});
        vecs.push_back('{0, 7'd2, 3'd5, 8'h00, 0, 1, 0, 8'h33, 0, 64'h0});
        vecs.push_back('{1, 7'd3, 3'd7, 8'h77, 4, 7, 0, 8'h00, 1, 64'h7700000000000000});
        vecs.push_back('{1, 7'd2, 3'd7, 8'h99, 0, 3, 0, 8'h00, 1, 64'h9900000000000000});
        vecs.push_back('{0, 7'd2, 3'd7, 8'h00, 0, 1, 0, 8'h99, 0, 64'h0});
        vecs.push_back('{0, 7'd2, 3'd1, 8'h00, 0, 1, 0, 8'h00, 0, 64'h0});
        vecs.push_back('{0, 7'd9, 3'd0, 8'h00, 6, 6, 1, 8'h00, 0, 64'h0});
        vecs.push_back('{0, 7'd2, 3'd7, 8'h00, 0, 3, 0, 8'h99, 0, 64'h0});

        foreach (vecs[i]) begin
            doReq(vecs[i].wr, vecs[i].idx, vecs[i].lane, vecs[i].data, vecs[i].k,
                  oLat, oErr, oData, oWord);
            check($sformatf("v%0d_lat", i), oLat, vecs[i].lat);
            check($sformatf("v%0d_err", i), oErr, vecs[i].err);
            check($sformatf("v%0d_data", i), oData, vecs[i].rdata);
            if (vecs[i].wrExp) check($sformatf("v%0d_word", i), oWord, vecs[i].wword);
        end

        // Reset during ACCESS of a commit: no strobe survives, staging is lost.
        doReq(1, 7'd1, 3'd0, 8'h42, 0, oLat, oErr, oData, oWord);
        while (dbgReqReady_o !== 1'b1) @(negedge clk);
        dbgReqValid_i = 1; dbgReqWrite_i = 1; dbgReqAddr_i = {7'd1, 3'd7}; dbgReqWrData_i = 8'h10;
        @(negedge clk);
        dbgReqValid_i = 0;
        pipeQuiet_i = 1;
        check("abort_stall_pre", stallReq_o, 1);
        @(negedge clk);
        check("abort_access_wren", prfWrEn_o, 1);
        w0 = envWrites;
        reset = 0;
        #1;
        check("abort_stall_drop", stallReq_o, 0);
        check("abort_wren_drop", prfWrEn_o, 0);
        check("abort_ready", dbgReqReady_o, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        modelReset();
        #1;
        check("abort_no_write", envWrites, w0);
        check("abort_mem", prfMem[1], refMem[1]);
        check("abort_ready_back", dbgReqReady_o, 1);
        doReq(1, 7'd1, 3'd7, 8'h5C, 0, oLat, oErr, oData, oWord);
        check("abort_recommit", oWord, 64'h5C00000000000000);

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int kk;
            kk = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            doReq(1'($urandom_range(0, 1)), 7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  8'($urandom), kk, oLat, oErr, oData, oWord);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
